// File: rtl/timing_pkg.sv
// Shared word widths and saturating arithmetic helpers for the symbol-timing chain
// (TED, loop filter/NCO, interpolator).
package timing_pkg;

  localparam int CTRL_W  = 24;
  localparam int PHASE_W = 24;

  typedef logic signed [CTRL_W-1:0] ctrl_t;
  typedef logic        [PHASE_W-1:0] phase_t;

  // Nominal NCO increment: ceil(2^w / osf), so an open loop never runs slow.
  function automatic longint nom_inc(input int osf, input int w);
    return ((longint'(1) << w) + longint'(osf) - 1) / longint'(osf);
  endfunction

  function automatic logic signed [63:0] sat_lim(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Symmetric clip to +/-(2^(w-1)-1); the most negative code is never produced.
  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] x, input int w);
    logic signed [63:0] lim;
    lim = sat_lim(w);
    if (x > lim)       return lim;
    else if (x < -lim) return -lim;
    else               return x;
  endfunction

  function automatic logic signed [63:0] sat_shr(input logic signed [63:0] x, input int sh,
                                                 input int w);
    return sat_clip(x >>> sh, w);
  endfunction

  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b, input int w);
    return sat_clip(a + b, w);
  endfunction

endpackage

// File: rtl/timing_loop_filter.sv
// Proportional-integral loop filter: saturating integrator, saturating proportional path,
// and a final clamp that keeps the downstream NCO increment strictly positive.
module timing_loop_filter
  import timing_pkg::*;
#(
  parameter int     ERR_W     = 32,
  parameter int     KP_SHIFT  = 8,
  parameter int     KI_SHIFT  = 16,
  parameter int     INT_W     = 24,
  parameter longint CLAMP_LIM = 419430
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [ERR_W-1:0] err_in,
  input  logic                    err_valid,
  input  logic                    loop_en,
  output logic signed [INT_W-1:0] ctrl_out
);

  logic signed [INT_W-1:0] integ_p1;
  logic signed [INT_W-1:0] integ_p0;
  logic signed [INT_W-1:0] prop_p0;
  logic signed [INT_W-1:0] ctrl_p0;

  function automatic logic signed [63:0] clamp_ctrl(input logic signed [63:0] x);
    if (x > CLAMP_LIM)       return CLAMP_LIM;
    else if (x < -CLAMP_LIM) return -CLAMP_LIM;
    else                     return x;
  endfunction

  // p0: filter arithmetic on the incoming error
  always_comb begin
    integ_p0 = INT_W'(sat_add(64'(integ_p1), 64'(err_in) >>> KI_SHIFT, INT_W));
    prop_p0  = INT_W'(sat_shr(64'(err_in), KP_SHIFT, INT_W));
    ctrl_p0  = INT_W'(clamp_ctrl(64'(integ_p0) + 64'(prop_p0)));
  end

  // p1: registered integrator and control word
  always_ff @(posedge clk) begin
    if (reset || !loop_en) begin
      integ_p1 <= '0;
      ctrl_out <= '0;
    end else if (err_valid) begin
      integ_p1 <= integ_p0;
      ctrl_out <= ctrl_p0;
    end
  end

endmodule

// File: rtl/timing_loop_nco.sv
// Symbol-timing loop: PI-filtered TED error steers a phase-accumulator NCO that emits
// a symbol strobe and fractional interval mu on every phase wrap.
module timing_loop_nco
  import timing_pkg::*;
#(
  parameter int OVERSAMPLE_FACTOR = 20,
  parameter int ERR_W             = 32,
  parameter int KP_SHIFT          = 8,
  parameter int KI_SHIFT          = 16,
  parameter int INT_W             = 24,
  parameter int NCO_W             = 24,
  parameter int MU_W              = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_valid,
  input  logic signed [ERR_W-1:0] err_in,
  input  logic                    err_valid,
  input  logic                    loop_en,
  output logic                    sym_strobe,
  output logic [MU_W-1:0]         mu,
  output logic signed [INT_W-1:0] ctrl_out
);

  localparam longint        NOM_INC_L = nom_inc(OVERSAMPLE_FACTOR, NCO_W);
  localparam logic [NCO_W:0] NOM_INC  = (NCO_W + 1)'(NOM_INC_L);
  localparam longint        CLAMP_LIM = NOM_INC_L / 2;

  logic [NCO_W-1:0] phase_p1;
  logic [NCO_W:0]   ctrl_x;
  logic [NCO_W:0]   sum_p0;

  timing_loop_filter #(
    .ERR_W    (ERR_W),
    .KP_SHIFT (KP_SHIFT),
    .KI_SHIFT (KI_SHIFT),
    .INT_W    (INT_W),
    .CLAMP_LIM(CLAMP_LIM)
  ) u_filter (
    .clk      (clk),
    .reset    (reset),
    .err_in   (err_in),
    .err_valid(err_valid),
    .loop_en  (loop_en),
    .ctrl_out (ctrl_out)
  );

  // p0: the clamp keeps the true sum inside [0, 2^(NCO_W+1)), so modulo arithmetic
  // at NCO_W+1 bits is exact and the top bit is the wrap flag.
  assign ctrl_x = (NCO_W + 1)'(ctrl_out);
  assign sum_p0 = {1'b0, phase_p1} + NOM_INC - ctrl_x;

  // p1: phase accumulator, strobe and mu registers
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_p1   <= '0;
      sym_strobe <= 1'b0;
      mu         <= '0;
    end else if (sample_valid) begin
      phase_p1   <= sum_p0[NCO_W-1:0];
      sym_strobe <= sum_p0[NCO_W];
      if (sum_p0[NCO_W]) mu <= sum_p0[NCO_W-1 -: MU_W];
    end else begin
      sym_strobe <= 1'b0;
    end
  end

endmodule

// File: doc/timing_loop_nco.md
Name: timing_loop_nco

Overview:
Symbol-timing recovery loop stage directly downstream of the Gardner TED. It consumes the per-symbol timing error, filters it through a proportional-integral (PI) loop filter, and steers a phase-accumulator NCO. The NCO emits one symbol strobe plus a fractional-interval estimate (mu) per recovered symbol; these drive the interpolator/decimator and re-time the TED sampling window.

Parameters:
OVERSAMPLE_FACTOR, 20, nominal input samples per symbol (>=2)
ERR_W, 32, signed width of the timing-error input
KP_SHIFT, 8, proportional gain = 2^-KP_SHIFT (arithmetic right shift)
KI_SHIFT, 16, integral gain = 2^-KI_SHIFT (arithmetic right shift)
INT_W, 24, signed integrator width
NCO_W, 24, unsigned NCO phase width (modulo 2^NCO_W)
MU_W, 16, unsigned fractional-interval output width

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
sample_valid  in  1  one oversampled input sample this cycle; advances the NCO
err_in  in  ERR_W  signed timing error from the TED
err_valid  in  1  err_in valid this cycle (one cycle per symbol)
loop_en  in  1  0 = open loop: control forced to 0, integrator held at 0
sym_strobe  out  1  one-cycle pulse on NCO wrap
mu  out  MU_W  fractional interval, updated with sym_strobe
ctrl_out  out  INT_W  signed control word currently applied to the NCO (debug)

Behaviour:
- Single clock domain, clk only. All registers reset synchronously on reset=1; reset mid-operation clears all state on the next edge.
- Reset values: sym_strobe=0, mu=0, ctrl_out=0, integrator=0, NCO phase=0.
- NOM_INC = ceil(2^NCO_W / OVERSAMPLE_FACTOR), an elaboration-time constant.
- Loop filter updates only on cycles with err_valid=1 and loop_en=1:
  - prop = err_in >>> KP_SHIFT
  - integ_next = sat_INT_W(integ + (err_in >>> KI_SHIFT))
  - ctrl = clamp(integ_next + sat_INT_W(prop), +/-(NOM_INC/2))
  - Result is registered into ctrl_out: 1-cycle latency from err_valid.
- Saturation is symmetric: +(2^(INT_W-1)-1) and -(2^(INT_W-1)-1). Saturation never wraps.
- The clamp keeps the NCO increment strictly positive.
- loop_en=0: integrator and ctrl_out forced to 0 on the next edge; err_valid is ignored.
- NCO, on cycles with sample_valid=1:
  - sum = phase + NOM_INC - ctrl_out, computed at NCO_W+1 bits.
  - Positive error slows the NCO (later strobe).
  - If sum >= 2^NCO_W: phase <= sum - 2^NCO_W; sym_strobe <= 1; mu <= (sum - 2^NCO_W)[NCO_W-1 -: MU_W].
  - Otherwise: phase <= sum; sym_strobe <= 0; mu holds.
- sample_valid=0: phase holds, sym_strobe=0, mu holds.
- sym_strobe registered: asserts the cycle after the wrapping sample. It is never high on two consecutive cycles unless two consecutive valid samples both wrap (impossible while the clamp holds).
- err_valid and sample_valid in the same cycle: the NCO uses the ctrl_out value from before this update. The new control takes effect on the next valid sample.
- err_valid without a preceding strobe is legal; it is filtered normally.

Decomposition:
- Package timing_pkg holds:
  - function nom_inc(int osf, int w)
  - saturating add/shift helper functions sat_add, sat_shr
  - typedefs for the ctrl and phase word widths, shared with the TED and the interpolator.
- One sub-module, timing_loop_filter: the PI filter with saturation and clamp. The NCO stays in the top level.

Test Plan:
- Open loop, phase 0: reset, then loop_en=0 with sample_valid=1 every cycle (OSF=20, NOM_INC=838861) -> first sym_strobe after the 20th valid sample, then every 20 samples; mu=0 on the first strobe; ctrl_out stays 0.
- Gapped samples: sample_valid toggling 1/0 -> strobe period doubles to 40 cycles; sym_strobe never asserts on a cycle following sample_valid=0.
- Single error pulse: loop_en=1, one err_valid with err_in=+65536 -> ctrl_out=256+1=257 one cycle later; a further err_valid with err_in=0 -> ctrl_out=1 (integrator retained).
- Saturation and clamp: err_in=+2^31-1 on every err_valid -> ctrl_out saturates at +419430 (NOM_INC/2) and never wraps negative; strobe interval stays bounded at 40 samples or fewer.
- Simultaneous events and reset: err_valid on the same cycle as the wrapping sample -> that strobe uses the old ctrl. Assert reset mid-symbol -> next edge gives phase=0, ctrl_out=0, sym_strobe=0, mu=0.
- Closed-loop lock: drive a TED model fed by an MSK source with a 0.3-sample timing offset -> ctrl_out settles within 2000 symbols; |mean err| below 1% of full-scale over the last 500 symbols.
